alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one combinational 16-bit ALU between two requesters. Each requester submits an operation (a, b, carry-in, 3-bit opcode) over a valid/ready handshake. The block grants requesters round-robin, holds the operands on the ALU for a fixed settling time, captures the result and flags, and returns them over a per-requester response handshake. It sits between the ALU datapath and the two client blocks; the ALU itself is external to this block.

## Interface
- ALU_LAT, 1: cycles the operands are held on the ALU before the result is captured; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  request pending.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  16  operands.
- req0_cin / req1_cin  in  1  carry-in.
- req0_opc / req1_opc  in  3  ALU opcode.
- rsp0_valid / rsp1_valid  out  1  result available for that requester.
- rsp0_ready / rsp1_ready  in  1  requester takes the result.
- rsp_w  out  16  captured ALU result; shared by both requesters, qualified by rspN_valid.
- rsp_f  out  2  captured ALU flags {f1, f0}.
- alu_a, alu_b  out  16  ALU operand drive.
- alu_cin  out  1  ALU carry-in drive.
- alu_opc  out  3  ALU opcode drive.
- alu_w  in  16  ALU result.
- alu_f  in  2  ALU flags.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - EXEC: operands held on the ALU.
  - RESP: result presented to the granted requester.
- Grant is computed combinationally in IDLE only.
  - Exactly one of reqN_ready may be high at a time, and it is high only if the matching reqN_valid is high.
  - If both requesters are valid, the one not most recently served wins.
  - Priority pointer reset value: port 0 preferred.
- Accept (IDLE, reqN_valid & reqN_ready):
  - Operands are latched into the registers that drive alu_*.
  - The grant index is recorded.
  - The latency counter is loaded with ALU_LAT-1.
  - Next state is EXEC.
- EXEC:
  - The counter decrements each cycle.
  - When the counter is 0, alu_w and alu_f are captured into rsp_w and rsp_f, and next state is RESP.
- RESP:
  - Only the granted rspN_valid is high.
  - On rspN_ready the state returns to IDLE, and the priority pointer moves to the other port.
  - rsp_w and rsp_f hold their value until the next capture.
- The alu_* drive registers hold their last value outside EXEC; they change only on accept.
- Requests arriving during EXEC or RESP are stalled (ready low). They must remain asserted with stable payload; this is a requester obligation, not checked by this block.
- Ready/response on the non-granted port is always low.
- Reset value of every output is 0. The pointer resets to port 0 and the state to IDLE.
- Reset mid-operation discards the in-flight operation. No response is issued for it.

## Timing
- Accept edge k → capture at edge k+ALU_LAT → rspN_valid high from the cycle after edge k+ALU_LAT.
- Minimum occupancy: ALU_LAT+2 cycles per operation (accept, ALU_LAT exec cycles, one response cycle with rsp_ready already high). IDLE lasts at least one cycle between operations.
- rspN_valid, once high, stays high until handshake completes. rsp_ready held low stalls indefinitely.
- reqN_ready is combinational from reqN_valid and state.
- rspN_valid, rsp_w, rsp_f, alu_* and busy are registered.

## Configuration
- ALU_ARB_STATS_EN defined:
  - Adds outputs cnt0 and cnt1 (16 bits each, reset 0).
  - Each counts completed responses for its port and saturates at 16'hFFFF.
  - Counters are cleared only by rst.
- ALU_ARB_STATS_EN undefined:
  - No counters or ports.
  - Behaviour is otherwise identical.

## Test plan
- Single request (ALU_LAT=1): port0 a=16'h0003, b=16'h0004, cin=0, opc=0 with a reference ALU → req0_ready high in IDLE, rsp0_valid two cycles after accept, rsp_w equals the reference result, rsp1_valid stays 0.
- Contention: both ports valid from reset → port0 granted first, then port1, then port0. Each response carries that port's operands' result.
- Back-pressure: hold rsp1_ready low 5 cycles → rsp1_valid, rsp_w and rsp_f stable throughout; busy high; req0_ready low even with req0_valid high.
- Latency parameter: ALU_LAT=4 → alu_* stable for 4 cycles after accept; capture on the 4th edge; rsp valid on the following cycle.
- Reset mid-EXEC: assert rst asynchronously during EXEC → all outputs 0 immediately, state IDLE, no response issued, next request to port0 served normally.
- Stats (ALU_ARB_STATS_EN): 3 port0 and 2 port1 completions → cnt0=3, cnt1=2. Preload condition via 65537 completions → cnt0=16'hFFFF.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional per-port completion counters (cnt0/cnt1) when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_cin,
  input  logic [2:0]  req0_opc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_cin,
  input  logic [2:0]  req1_opc,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_w,
  output logic [1:0]  rsp_f,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic [2:0]  alu_opc,
  input  logic [15:0] alu_w,
  input  logic [1:0]  alu_f,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0] cnt0,
  output logic [15:0] cnt1,
`endif
  output logic        busy
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            ptr;
  logic            gnt;
  logic [CW-1:0]   cnt;
  logic            sel;
  logic            accept;
  logic            capture;
  logic            done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = EXEC;
      EXEC:    if (capture) state_nxt = RESP;
      RESP:    if (done)    state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Grant, ready and per-state strobes; ptr names the preferred port on contention
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sel        = ptr;
    accept     = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (!rst) begin
        sel        = (req0_valid && req1_valid) ? ptr : req1_valid;
        accept     = req0_valid | req1_valid;
        req0_ready = accept & ~sel;
        req1_ready = accept & sel;
      end
      EXEC:    capture = (cnt == '0);
      RESP:    done    = gnt ? rsp1_ready : rsp0_ready;
      default: ;
    endcase
  end

  // Operand drive, latency counter, result capture and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= 1'b0;
      ptr        <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_opc    <= '0;
      rsp_w      <= '0;
      rsp_f      <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (accept) begin
        gnt     <= sel;
        cnt     <= CW'(ALU_LAT - 1);
        alu_a   <= sel ? req1_a   : req0_a;
        alu_b   <= sel ? req1_b   : req0_b;
        alu_cin <= sel ? req1_cin : req0_cin;
        alu_opc <= sel ? req1_opc : req0_opc;
      end else if (state == EXEC && !capture) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        rsp_w <= alu_w;
        rsp_f <= alu_f;
      end
      if (done) ptr <= ~gnt;
      rsp0_valid <= (state_nxt == RESP) && !gnt;
      rsp1_valid <= (state_nxt == RESP) && gnt;
      busy       <= (state_nxt != IDLE);
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating completed-response counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (done) begin
      if (!gnt && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
      if (gnt  && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=4.
module tb_alu_share_arbiter;

  logic clk, rst;
  int   checks, errors;

  // Instance A (ALU_LAT=1)
  logic        v0, v1, r0, r1, rv0, rv1, rr0, rr1, c0, c1, ac, busy;
  logic [15:0] a0, b0, a1, b1, rw, aa, ab, aw;
  logic [2:0]  o0, o1, ao;
  logic [1:0]  rf, af;
  // Instance B (ALU_LAT=4)
  logic        v0_4, v1_4, r0_4, r1_4, rv0_4, rv1_4, rr0_4, rr1_4, c0_4, ac4, busy4;
  logic [15:0] a0_4, b0_4, rw4, aa4, ab4, aw4;
  logic [2:0]  o0_4, ao4;
  logic [1:0]  rf4, af4;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0, cnt1, cnt0_4, cnt1_4;
`endif

  // Reference ALU: returns {carry, zero, w}
  function automatic logic [17:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic [2:0] op);
    logic [16:0] r;
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b} + 17'(cin);
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {a, 1'b0};
      3'd6:    r = {a[0], 1'b0, a[15:1]};
      default: r = {1'b0, a};
    endcase
    return {r[16], (r[15:0] == 16'h0000), r[15:0]};
  endfunction

  assign {af, aw}   = alu_ref(aa, ab, ac, ao);
  assign {af4, aw4} = alu_ref(aa4, ab4, ac4, ao4);

  alu_share_arbiter #(.ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_cin(c0), .req0_opc(o0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_cin(c1), .req1_opc(o1),
    .rsp0_valid(rv0), .rsp0_ready(rr0), .rsp1_valid(rv1), .rsp1_ready(rr1),
    .rsp_w(rw), .rsp_f(rf),
    .alu_a(aa), .alu_b(ab), .alu_cin(ac), .alu_opc(ao), .alu_w(aw), .alu_f(af),
`ifdef ALU_ARB_STATS_EN
    .cnt0(cnt0), .cnt1(cnt1),
`endif
    .busy(busy)
  );

  alu_share_arbiter #(.ALU_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(v0_4), .req0_ready(r0_4), .req0_a(a0_4), .req0_b(b0_4), .req0_cin(c0_4), .req0_opc(o0_4),
    .req1_valid(v1_4), .req1_ready(r1_4), .req1_a(16'h0000), .req1_b(16'h0000), .req1_cin(1'b0), .req1_opc(3'd0),
    .rsp0_valid(rv0_4), .rsp0_ready(rr0_4), .rsp1_valid(rv1_4), .rsp1_ready(rr1_4),
    .rsp_w(rw4), .rsp_f(rf4),
    .alu_a(aa4), .alu_b(ab4), .alu_cin(ac4), .alu_opc(ao4), .alu_w(aw4), .alu_f(af4),
`ifdef ALU_ARB_STATS_EN
    .cnt0(cnt0_4), .cnt1(cnt1_4),
`endif
    .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if ({r0, r1, rv0, rv1, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctl_a got %b want 00000", {r0, r1, rv0, rv1, busy}); end
    checks++; if ({rw, rf, aa, ab} !== 50'b0) begin errors++; $display("FAIL reset_data_a got %h want 0", {rw, rf, aa, ab}); end
    checks++; if ({rv0_4, rv1_4, busy4, rw4, aa4} !== 35'b0) begin errors++; $display("FAIL reset_b got %h want 0", {rv0_4, rv1_4, busy4, rw4, aa4}); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    a0 = 16'h0003; b0 = 16'h0004; c0 = 1'b0; o0 = 3'd0; v0 = 1'b1; rr0 = 1'b1;
    #1;
    checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL single_ready got r0=%b r1=%b want 1 0", r0, r1); end
    step();
    v0 = 1'b0;
    checks++; if (busy !== 1'b1 || aa !== 16'h0003 || ab !== 16'h0004 || rv0 !== 1'b0) begin
      errors++; $display("FAIL single_exec got busy=%b aa=%h ab=%h rv0=%b want 1 0003 0004 0", busy, aa, ab, rv0); end
    step();
    checks++; if (rv0 !== 1'b1 || rv1 !== 1'b0) begin errors++; $display("FAIL single_rsp_valid got %b%b want 10", rv0, rv1); end
    checks++; if (rw !== 16'h0007 || rf !== 2'b00) begin errors++; $display("FAIL single_rsp_data got %h/%b want 0007/00", rw, rf); end
    step();
    checks++; if (rv0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got rv0=%b busy=%b want 0 0", rv0, busy); end
  endtask

  task automatic test_contention();
    logic [15:0] exp_w [3];
    logic [1:0]  exp_f [3];
    logic        exp_p [3];
    exp_p[0] = 1'b0; exp_w[0] = 16'h0000; exp_f[0] = 2'b01;
    exp_p[1] = 1'b1; exp_w[1] = 16'h0000; exp_f[1] = 2'b11;
    exp_p[2] = 1'b0; exp_w[2] = 16'h1200; exp_f[2] = 2'b00;
    rst = 1'b1; #2; rst = 1'b0;
    step();
    a0 = 16'h00F0; b0 = 16'h0F0F; c0 = 1'b0; o0 = 3'd2;
    a1 = 16'hFFFF; b1 = 16'h0001; c1 = 1'b0; o1 = 3'd0;
    v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
    #1;
    checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL cont_first_grant got r0=%b r1=%b want 1 0", r0, r1); end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 12 && !(rv0 || rv1); i++) step();
      checks++; if (rv0 !== !exp_p[k] || rv1 !== exp_p[k]) begin
        errors++; $display("FAIL cont_order[%0d] got rv0=%b rv1=%b want port %0d", k, rv0, rv1, exp_p[k]); end
      checks++; if (rw !== exp_w[k] || rf !== exp_f[k]) begin
        errors++; $display("FAIL cont_data[%0d] got %h/%b want %h/%b", k, rw, rf, exp_w[k], exp_f[k]); end
      if (k == 0) begin a0 = 16'h1234; b0 = 16'h0034; o0 = 3'd1; end
      if (k == 2) begin v0 = 1'b0; v1 = 1'b0; end
      step();
    end
  endtask

  task automatic test_back_pressure();
    a1 = 16'h8001; b1 = 16'h0000; c1 = 1'b0; o1 = 3'd5; v1 = 1'b1; rr1 = 1'b0;
    for (int i = 0; i < 12 && !rv1; i++) begin
      step();
      if (busy) v1 = 1'b0;
    end
    v1 = 1'b0;
    a0 = 16'h0F00; b0 = 16'h00F0; c0 = 1'b0; o0 = 3'd3; v0 = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rv1 !== 1'b1 || rw !== 16'h0002 || rf !== 2'b10 || busy !== 1'b1 || r0 !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got rv1=%b rw=%h rf=%b busy=%b r0=%b want 1 0002 10 1 0", i, rv1, rw, rf, busy, r0); end
      step();
    end
    rr1 = 1'b1;
    step();
    checks++; if (rv1 !== 1'b0 || r0 !== 1'b1) begin errors++; $display("FAIL bp_release got rv1=%b r0=%b want 0 1", rv1, r0); end
    step();
    v0 = 1'b0; rr0 = 1'b1;
    for (int i = 0; i < 12 && !rv0; i++) step();
    checks++; if (rv0 !== 1'b1 || rw !== 16'h0FF0 || rf !== 2'b00) begin
      errors++; $display("FAIL bp_next got rv0=%b rw=%h rf=%b want 1 0FF0 00", rv0, rw, rf); end
    step();
  endtask

  task automatic test_latency();
    a0_4 = 16'h1234; b0_4 = 16'h1111; c0_4 = 1'b1; o0_4 = 3'd0; v0_4 = 1'b1; rr0_4 = 1'b1;
    #1;
    checks++; if (r0_4 !== 1'b1) begin errors++; $display("FAIL lat_ready got %b want 1", r0_4); end
    step();
    v0_4 = 1'b0; a0_4 = 16'hDEAD; b0_4 = 16'hBEEF; o0_4 = 3'd7;
    for (int i = 0; i < 4; i++) begin
      checks++; if (aa4 !== 16'h1234 || ab4 !== 16'h1111 || ac4 !== 1'b1 || rv0_4 !== 1'b0) begin
        errors++; $display("FAIL lat_exec[%0d] got aa=%h ab=%h cin=%b rv0=%b want 1234 1111 1 0", i, aa4, ab4, ac4, rv0_4); end
      step();
    end
    checks++; if (rv0_4 !== 1'b1 || rw4 !== 16'h2346 || rf4 !== 2'b00 || aa4 !== 16'h1234) begin
      errors++; $display("FAIL lat_rsp got rv0=%b rw=%h rf=%b aa=%h want 1 2346 00 1234", rv0_4, rw4, rf4, aa4); end
    step();
    checks++; if (rv0_4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL lat_done got rv0=%b busy=%b want 0 0", rv0_4, busy4); end
  endtask

  task automatic test_reset_mid_exec();
    a0_4 = 16'hAAAA; b0_4 = 16'h5555; c0_4 = 1'b0; o0_4 = 3'd4; v0_4 = 1'b1; rr0_4 = 1'b1;
    step();
    v0_4 = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if ({rv0_4, rv1_4, busy4, r0_4} !== 4'b0 || rw4 !== 16'h0000 || aa4 !== 16'h0000 || ab4 !== 16'h0000) begin
      errors++; $display("FAIL rstmid_outputs got rv=%b%b busy=%b rw=%h aa=%h ab=%h want all 0", rv0_4, rv1_4, busy4, rw4, aa4, ab4); end
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (rv0_4 !== 1'b0 || busy4 !== 1'b0) begin
        errors++; $display("FAIL rstmid_no_rsp[%0d] got rv0=%b busy=%b want 0 0", i, rv0_4, busy4); end
    end
    a0_4 = 16'h00FF; b0_4 = 16'h0001; c0_4 = 1'b0; o0_4 = 3'd0; v0_4 = 1'b1;
    #1;
    checks++; if (r0_4 !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", r0_4); end
    step();
    v0_4 = 1'b0;
    for (int i = 0; i < 12 && !rv0_4; i++) step();
    checks++; if (rv0_4 !== 1'b1 || rw4 !== 16'h0100 || rf4 !== 2'b00) begin
      errors++; $display("FAIL rstmid_next got rv0=%b rw=%h rf=%b want 1 0100 00", rv0_4, rw4, rf4); end
    step();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic stats_op(input logic port);
    if (port) begin v1 = 1'b1; rr1 = 1'b1; end
    else      begin v0 = 1'b1; rr0 = 1'b1; end
    step();
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 12 && !(rv0 || rv1); i++) step();
    step();
  endtask

  task automatic test_stats();
    rst = 1'b1; #2; rst = 1'b0;
    step();
    stats_op(1'b0); stats_op(1'b1); stats_op(1'b0); stats_op(1'b1); stats_op(1'b0);
    checks++; if (cnt0 !== 16'd3 || cnt1 !== 16'd2) begin
      errors++; $display("FAIL stats_counts got %0d/%0d want 3/2", cnt0, cnt1); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    {v0, v1, c0, c1, rr0, rr1} = '0;
    {a0, b0, a1, b1} = '0;
    o0 = '0; o1 = '0;
    {v0_4, v1_4, c0_4, rr0_4, rr1_4} = '0;
    a0_4 = '0; b0_4 = '0; o0_4 = '0;
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_latency();
    test_reset_mid_exec();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
